// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 boot controller: sequencer states, MU0 opcodes,
// default bus widths.
package mu0_pkg;

  localparam int MU0_ADDR_W = 12;
  localparam int MU0_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } boot_state_e;

  // MU0 instruction word is {opcode[3:0], address[11:0]}
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

endpackage

// File: rtl/mu0_mem_mux.sv
// Memory port mux: CPU pass-through while running, loader write strobe while
// loading, otherwise an idle read with zeroed address/data.
module mu0_mem_mux #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int PTR_W  = 5
) (
  input  logic              i_run,
  input  logic              i_wr_stb,
  input  logic [PTR_W-1:0]  i_ptr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_cpu_memrq,
  input  logic              i_cpu_rnw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_mem_memrq,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata
);

  always_comb begin
    o_mem_memrq = 1'b0;
    o_mem_rw    = 1'b1;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_run) begin
      o_mem_memrq = i_cpu_memrq;
      o_mem_rw    = i_cpu_rnw;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (i_wr_stb) begin
      o_mem_memrq = 1'b1;
      o_mem_rw    = 1'b0;
      o_mem_addr  = ADDR_W'(i_ptr);
      o_mem_wdata = i_load_data;
    end
  end

endmodule

// File: rtl/mu0_boot_ctrl.sv
// Boot sequencer: streams a loader image into memory from address 0 with MU0 held
// in reset, holds reset for RST_HOLD cycles, then hands the memory port to MU0.
module mu0_boot_ctrl
  import mu0_pkg::*;
#(
  parameter int ADDR_W    = MU0_ADDR_W,
  parameter int DATA_W    = MU0_DATA_W,
  parameter int MEM_DEPTH = 32,
  parameter int RST_HOLD  = 3,
  localparam int PTR_W    = $clog2(MEM_DEPTH),
  localparam int CNT_W    = PTR_W + 1,
  localparam int HOLD_W   = $clog2(RST_HOLD + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_cpu_memrq,
  input  logic              i_cpu_rnw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_mem_memrq,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_boot_done,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_words_loaded
);

  boot_state_e       r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic              r_cpu_rst_n;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_words;

  logic w_xfer;
  logic w_at_end;

  assign w_xfer   = (r_state == ST_LOAD) && i_load_valid;
  assign w_at_end = (r_ptr == PTR_W'(MEM_DEPTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_cpu_rst_n <= 1'b0;
      r_overflow  <= 1'b0;
      r_words     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state    <= ST_LOAD;
          r_ptr      <= '0;
          r_words    <= '0;
          r_overflow <= 1'b0;
        end
        ST_LOAD: if (w_xfer) begin
          r_ptr   <= r_ptr + PTR_W'(1);
          r_words <= r_words + CNT_W'(1);
          if (i_load_last || w_at_end) begin
            r_state <= ST_HOLD;
            r_hold  <= '0;
          end
          // Memory full without an end marker: image truncated
          if (w_at_end && !i_load_last) r_overflow <= 1'b1;
        end
        ST_HOLD: begin
          if (r_hold == HOLD_W'(RST_HOLD - 1)) begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        ST_RUN: if (i_start) begin
          r_state     <= ST_LOAD;
          r_cpu_rst_n <= 1'b0;
          r_ptr       <= '0;
          r_words     <= '0;
          r_overflow  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_load_ready   = (r_state == ST_LOAD);
  assign o_busy         = (r_state == ST_LOAD) || (r_state == ST_HOLD);
  assign o_boot_done    = (r_state == ST_RUN);
  assign o_cpu_rst_n    = r_cpu_rst_n;
  assign o_overflow     = r_overflow;
  assign o_words_loaded = r_words;

  mu0_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_mux (
    .i_run       (r_state == ST_RUN),
    .i_wr_stb    (w_xfer),
    .i_ptr       (r_ptr),
    .i_load_data (i_load_data),
    .i_cpu_memrq (i_cpu_memrq),
    .i_cpu_rnw   (i_cpu_rnw),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .o_mem_memrq (o_mem_memrq),
    .o_mem_rw    (o_mem_rw),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata)
  );

endmodule

// File: tb/tb_mu0_boot_ctrl.sv
// Bench for mu0_boot_ctrl: behavioural boot model checked every cycle, a stand-in
// memory fed from the DUT's memory port, and a behavioural MU0 running a sum program.
module tb_mu0_boot_ctrl;
  import mu0_pkg::*;

  localparam int DEPTH = 32;
  localparam int HOLD  = 3;
  localparam int S_IDLE = 0, S_LOAD = 1, S_HOLD = 2, S_RUN = 3;

  logic        clk = 1'b0;
  logic        rst, start, lv, ll, cm, crnw;
  logic [15:0] ld, cwd;
  logic [11:0] ca;
  logic        lr, crn, mm, mrw, busy, bd, ovf;
  logic [11:0] ma;
  logic [15:0] mwd;
  logic [5:0]  wl;

  always #5 clk = ~clk;

  mu0_boot_ctrl dut (
    .i_clk (clk), .i_rst (rst), .i_start (start),
    .i_load_valid (lv), .i_load_data (ld), .i_load_last (ll), .o_load_ready (lr),
    .i_cpu_memrq (cm), .i_cpu_rnw (crnw), .i_cpu_addr (ca), .i_cpu_wdata (cwd),
    .o_cpu_rst_n (crn), .o_mem_memrq (mm), .o_mem_rw (mrw), .o_mem_addr (ma),
    .o_mem_wdata (mwd), .o_busy (busy), .o_boot_done (bd), .o_overflow (ovf),
    .o_words_loaded (wl)
  );

  int total = 0, bad = 0;
  bit chk_en = 0, rand_cpu = 0;
  logic [15:0] mem [0:DEPTH-1];
  logic [15:0] img [0:63];

  // Behavioural model: phase, words written so far, hold cycles remaining
  int m_st = S_IDLE, m_cnt = 0, m_left = 0;
  bit m_ovf = 0, m_rstn = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_st = S_IDLE; m_cnt = 0; m_ovf = 0; m_rstn = 0;
    end else if (m_st == S_IDLE) begin
      if (start) begin m_st = S_LOAD; m_cnt = 0; m_ovf = 0; end
    end else if (m_st == S_LOAD) begin
      if (lv) begin
        m_cnt = m_cnt + 1;
        if (ll || m_cnt == DEPTH) begin
          m_ovf = !ll; m_st = S_HOLD; m_left = HOLD;
        end
      end
    end else if (m_st == S_HOLD) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_st = S_RUN; m_rstn = 1; end
    end else if (start) begin
      m_st = S_LOAD; m_cnt = 0; m_ovf = 0; m_rstn = 0;
    end
  end

  // Per-cycle compare plus the memory stand-in (written where the DUT strobes it)
  initial forever begin
    logic [40:0] e, g;
    logic e_mm, e_rw;
    logic [11:0] e_a;
    logic [15:0] e_d;
    @(negedge clk);
    if (mm === 1'b1 && mrw === 1'b0 && ma < 12'(DEPTH)) mem[ma[4:0]] = mwd;
    if (chk_en) begin
      e_mm = 1'b0; e_rw = 1'b1; e_a = '0; e_d = '0;
      if (m_st == S_RUN) begin
        e_mm = cm; e_rw = crnw; e_a = ca; e_d = cwd;
      end else if (m_st == S_LOAD && lv) begin
        e_mm = 1'b1; e_rw = 1'b0; e_a = 12'(m_cnt); e_d = ld;
      end
      e = {m_st == S_LOAD, m_st == S_LOAD || m_st == S_HOLD, m_st == S_RUN,
           m_rstn, m_ovf, 6'(m_cnt), e_mm, e_rw, e_a, e_d};
      g = {lr, busy, bd, crn, ovf, wl, mm, mrw, ma, mwd};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle_check t=%0t {rdy,busy,done,rstn,ovf,wl,memrq,rw,addr,wdata} got=%h exp=%h",
                 $time, g, e);
      end
    end
  end

  // Random CPU activity while the CPU must be ignored
  initial forever begin
    @(negedge clk);
    if (rand_cpu) begin
      #1;
      cm = 1'($urandom); crnw = 1'($urandom); ca = 12'($urandom); cwd = 16'($urandom);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n, input int last_idx, input bit gaps,
                        input int max_cyc, output int acc_n);
    int g;
    bit a;
    g = 0; acc_n = 0;
    while (acc_n < n && g < max_cyc) begin
      lv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld = img[acc_n];
      ll = lv ? (acc_n == last_idx) : 1'($urandom_range(0, 1));
      @(negedge clk);
      a = lv && lr;
      @(posedge clk); #1;
      g++;
      if (a) acc_n++;
    end
    lv = 1'b0; ll = 1'b0;
  endtask

  task automatic wait_run(input string nm);
    int g;
    g = 0;
    while (bd !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
    chk(nm, 32'(bd), 32'd1);
  endtask

  task automatic mem_match(input string nm, input int n);
    int m;
    m = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== img[i]) m++;
    chk(nm, m, 0);
  endtask

  // Behavioural MU0: fetch cycle, then one memory cycle for LDA/STO/ADD/SUB
  task automatic run_mu0(output bit halted);
    int pc, cyc;
    logic [15:0] acc, ir;
    pc = 0; cyc = 0; acc = '0; halted = 0;
    while (!halted && cyc < 300) begin
      cm = 1'b1; crnw = 1'b1; ca = 12'(pc); ir = mem[pc[4:0]];
      @(posedge clk); #1;
      cyc++; pc = pc + 1;
      case (ir[15:12])
        OP_LDA: begin ca = ir[11:0]; acc = mem[ir[4:0]]; @(posedge clk); #1; end
        OP_ADD: begin ca = ir[11:0]; acc = acc + mem[ir[4:0]]; @(posedge clk); #1; end
        OP_SUB: begin ca = ir[11:0]; acc = acc - mem[ir[4:0]]; @(posedge clk); #1; end
        OP_STO: begin
          crnw = 1'b0; ca = ir[11:0]; cwd = acc;
          @(posedge clk); #1;
        end
        OP_JMP: pc = int'(ir[11:0]);
        OP_JGE: if (!acc[15]) pc = int'(ir[11:0]);
        OP_JNE: if (acc != 0) pc = int'(ir[11:0]);
        OP_STP: halted = 1;
        default: ;
      endcase
    end
    cm = 1'b0; crnw = 1'b1;
  endtask

  initial begin
    int n, k, nw;
    bit h;
    logic [15:0] m7;
    rst = 1'b1; start = 1'b0; lv = 1'b0; ll = 1'b0; ld = '0;
    cm = 1'b0; crnw = 1'b1; ca = '0; cwd = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1;

    repeat (5) @(posedge clk);
    #1;
    chk("idle_rst_n", 32'(crn), 0);
    chk("idle_memrq", 32'(mm), 0);
    chk("idle_ready", 32'(lr), 0);
    chk("idle_done", 32'(bd), 0);

    // Sum of 1..8: loop adds N into SUM and decrements N until zero
    for (int i = 0; i < 21; i++) img[i] = '0;
    img[0] = {OP_LDA, 12'd18}; img[1] = {OP_ADD, 12'd16}; img[2] = {OP_STO, 12'd18};
    img[3] = {OP_LDA, 12'd16}; img[4] = {OP_SUB, 12'd19}; img[5] = {OP_STO, 12'd16};
    img[6] = {OP_JNE, 12'd0};  img[7] = {OP_STP, 12'd7};
    img[16] = 16'd8; img[19] = 16'd1;
    rand_cpu = 1;
    pulse_start();
    stream(21, 20, 0, 100, n);
    rand_cpu = 0; cm = 1'b0; crnw = 1'b1;
    chk("prog_accepted", n, 21);
    k = 0;
    while (crn !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("hold_cycles", k, 3);
    chk("prog_words", 32'(wl), 21);
    chk("mem16", 32'(mem[16]), 8);
    chk("mem19", 32'(mem[19]), 1);
    chk("prog_done", 32'(bd), 1);
    run_mu0(h);
    chk("mu0_halted", 32'(h), 1);
    chk("mem18_sum", 32'(mem[18]), 36);

    // Restart while MU0 is issuing reads
    for (int i = 0; i < 4; i++) begin
      cm = 1'b1; crnw = 1'b1; ca = 12'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    cm = 1'b1; ca = 12'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_rst_n", 32'(crn), 0);
    chk("restart_memrq", 32'(mm), 0);
    pulse_start();
    cm = 1'b0;
    img[0] = 16'($urandom); img[1] = 16'($urandom);
    stream(2, 1, 0, 50, n);
    chk("reload_accepted", n, 2);
    pulse_start();
    wait_run("reload_run");
    chk("reload_words", 32'(wl), 2);
    mem_match("reload_mem", 2);

    // Loader with random valid gaps
    for (int r = 0; r < 3; r++) begin
      nw = $urandom_range(5, 20);
      for (int i = 0; i < nw; i++) img[i] = 16'($urandom);
      pulse_start();
      rand_cpu = 1;
      stream(nw, nw - 1, 1, 400, n);
      rand_cpu = 0; cm = 1'b0; crnw = 1'b1;
      chk("gap_accepted", n, nw);
      wait_run("gap_run");
      chk("gap_words", 32'(wl), nw);
      mem_match("gap_mem", nw);
    end

    // Image longer than memory: 33rd word must never be taken
    for (int i = 0; i < 33; i++) img[i] = 16'($urandom);
    pulse_start();
    stream(33, -1, 0, 45, n);
    chk("ovf_accepted", n, 32);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_words", 32'(wl), 32);
    wait_run("ovf_run");
    mem_match("ovf_mem", 32);

    // Reset mid-load with pointer at 7
    m7 = mem[7];
    for (int i = 0; i < 8; i++) img[i] = 16'($urandom);
    pulse_start();
    stream(7, -1, 0, 50, n);
    chk("part_accepted", n, 7);
    chk("part_words", 32'(wl), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_words", 32'(wl), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(lr), 0);
    chk("rst_rst_n", 32'(crn), 0);
    mem_match("rst_mem_kept", 7);
    chk("rst_mem7", 32'(mem[7]), 32'(m7));
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mu0_boot_ctrl.md
Name: mu0_boot_ctrl

Overview:
Boot sequencer and memory-port arbiter between a host program loader, the MU0 core and memory_32x16. After `start`, it streams program/data words into memory from address 0 while holding MU0 in reset. It then waits a fixed reset-hold time, releases MU0 and hands the memory port to the core. Replaces bench-side force/release preloading with synthesizable logic.

Parameters:
ADDR_W, 12, memory/CPU address width
DATA_W, 16, memory data width
MEM_DEPTH, 32, number of writable words; legal load addresses are 0..MEM_DEPTH-1
RST_HOLD, 3, cycles MU0 reset stays asserted after the last load write (min 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to (re)load memory; honoured in IDLE and RUN only
load_valid  in  1  loader word valid
load_data  in  DATA_W  loader word
load_last  in  1  marks final word of image; qualified by load_valid
load_ready  out  1  controller accepts a word this cycle
cpu_memrq  in  1  MU0 memory request
cpu_rnw  in  1  MU0 read(1)/write(0)
cpu_addr  in  ADDR_W  MU0 address
cpu_wdata  in  DATA_W  MU0 write data
cpu_rst_n  out  1  MU0 reset, active-low, registered
mem_memrq  out  1  to memory memrq
mem_rw  out  1  to memory rw (1 = read, 0 = write)
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory in_data
busy  out  1  high in LOAD and HOLD
boot_done  out  1  high in RUN
overflow  out  1  sticky: image exceeded MEM_DEPTH
words_loaded  out  $clog2(MEM_DEPTH)+1  words written in last/current load

Behaviour:
- One clock `clk`; reset is synchronous and active-high (`rst`). All state updates on rising `clk`.
- States: IDLE, LOAD, HOLD, RUN. State, pointer, hold counter, `cpu_rst_n`, `overflow` and `words_loaded` are registers.
- Reset values: state=IDLE, `cpu_rst_n`=0, `overflow`=0, `words_loaded`=0, pointer=0. Resulting outputs: `load_ready`=0, `busy`=0, `boot_done`=0, `mem_memrq`=0, `mem_rw`=1, `mem_addr`=0, `mem_wdata`=0.
- `rst` mid-operation: immediate return to reset values on the next edge. Memory contents are not touched. A partial load is abandoned.
- IDLE: on `start` go to LOAD next cycle; pointer=0, `words_loaded`=0, `overflow`=0.
- LOAD:
  - `load_ready`=1.
  - Handshake: a word transfers when `load_valid && load_ready`. In that same cycle the memory outputs are driven combinationally: `mem_memrq`=1, `mem_rw`=0, `mem_addr`=pointer (zero-extended), `mem_wdata`=`load_data`. The memory writes on that edge, giving zero added latency.
  - No transfer: `mem_memrq`=0, `mem_rw`=1.
  - Each transfer increments the pointer and `words_loaded`.
  - Go to HOLD after a transfer with `load_last`=1, or after the transfer at pointer MEM_DEPTH-1.
  - If the MEM_DEPTH-1 transfer has `load_last`=0, set `overflow`. Further loader words see `load_ready`=0 and are not accepted.
  - `start` is ignored.
- HOLD:
  - `cpu_rst_n`=0, memory outputs idle (`mem_memrq`=0).
  - Hold counter counts RST_HOLD cycles, then state goes to RUN.
  - `cpu_rst_n` rises on the same edge that enters RUN.
  - `start` is ignored.
- RUN:
  - Memory outputs are a combinational pass-through of `cpu_memrq`, `cpu_rnw`, `cpu_addr` and `cpu_wdata`.
  - `boot_done`=1.
  - On `start`: next edge gives state=LOAD and `cpu_rst_n`=0, and the pointer and counters clear. The CPU pass-through ends in that cycle.
- MU0 read data goes directly from memory to the core and is not routed through this block.
- In IDLE, LOAD and HOLD all `cpu_*` inputs are ignored; the CPU can never write memory while its reset is asserted.
- Simultaneous `start` and `rst`: `rst` wins.

Decomposition:
- Shared package `mu0_pkg`:
  - state enum (IDLE/LOAD/HOLD/RUN)
  - MU0 opcode constants (LDA=0, STO=1, ADD=2, SUB=3, JMP=4, JGE=5, JNE=6, STP=7)
  - default ADDR_W/DATA_W
- One natural sub-module: `mu0_mem_mux`, the combinational port mux selected by state/write-strobe. The FSM stays in `mu0_boot_ctrl`.

Test Plan:
- Reset, then idle 5 cycles → `cpu_rst_n`=0, `mem_memrq`=0, `load_ready`=0, `boot_done`=0.
- `start`, then stream the 21-word sum-of-1..8 program (words 0–20, `load_last` on word 20), then RST_HOLD=3 → memory[16]=8, memory[19]=1, `words_loaded`=21. `cpu_rst_n` rises exactly 3 cycles after the last write. MU0 halts with memory[18]=36.
- Loader deasserts `load_valid` randomly during load → no `mem_memrq` in gap cycles; addresses remain contiguous 0..N-1.
- Stream 33 words with no `load_last` → 32 writes (addresses 0..31), `overflow`=1, 33rd word never accepted, `words_loaded`=32, then RUN.
- `start` pulsed in RUN mid-program → next cycle `cpu_rst_n`=0 and `cpu_memrq` is no longer passed through. Reload of a 2-word image (`words_loaded`=2) → RUN again. `start` pulsed during LOAD/HOLD → no effect.
- `rst` asserted in the middle of LOAD at pointer=7 → next cycle IDLE; words 0..6 retained in memory; `words_loaded`=0.
